// File: rtl/local_memory_arbiter_pkg.sv
// Shared types and constants for the local memory arbiter: FSM encoding,
// memory bus widths and the idle read pattern.
package local_memory_arbiter_pkg;

    localparam int MEM_ADDRESS_WIDTH = 24;
    localparam int MEM_DATA_WIDTH    = 32;
    localparam logic [MEM_DATA_WIDTH-1:0] MEM_IDLE_READ = ~32'h0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_CORE = 2'd1,
        OWN_WB   = 2'd2
    } arbState_t;

    function automatic logic [15:0] satInc16(input logic [15:0] value, input logic inc);
        return (inc && value != 16'hFFFF) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/local_memory_arbiter_starvation_counter.sv
// Saturating wait counter for the wishbone requester; atLimit tells the
// arbiter that the wishbone side must win the next arbitration.
module arbiter_starvation_counter
    import local_memory_arbiter_pkg::*;
#(
    parameter int LIMIT = 8,
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clear,
    output logic atLimit
);

    localparam logic [WIDTH-1:0] COUNT_MAX   = '1;
    localparam logic [WIDTH-1:0] LIMIT_VALUE = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && count != COUNT_MAX) begin
            count <= count + WIDTH'(1);
        end
    end

    assign atLimit = (count >= LIMIT_VALUE);

endmodule

// File: rtl/local_memory_arbiter.sv
// Two-way arbiter for the local SRAM request port: core has fixed priority,
// wishbone is protected by a starvation limit. Optional statistics counters
// are enabled with LOCAL_MEMORY_ARBITER_STATS_EN.
module local_memory_arbiter
    import local_memory_arbiter_pkg::*;
#(
    parameter int STARVATION_LIMIT   = 8,
    parameter int STARVE_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MEM_ADDRESS_WIDTH-1:0] coreAddress,
    input  logic [3:0]                   coreByteSelect,
    input  logic                         coreEnable,
    input  logic                         coreWriteEnable,
    input  logic [MEM_DATA_WIDTH-1:0]    coreDataWrite,
    output logic [MEM_DATA_WIDTH-1:0]    coreDataRead,
    output logic                         coreBusy,
    input  logic [MEM_ADDRESS_WIDTH-1:0] wbAddress,
    input  logic [3:0]                   wbByteSelect,
    input  logic                         wbEnable,
    input  logic                         wbWriteEnable,
    input  logic [MEM_DATA_WIDTH-1:0]    wbDataWrite,
    output logic [MEM_DATA_WIDTH-1:0]    wbDataRead,
    output logic                         wbBusy,
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
    input  logic                         statsClear,
    output logic [15:0]                  coreGrantCount,
    output logic [15:0]                  wbGrantCount,
    output logic [15:0]                  wbForcedGrantCount,
`endif
    output logic [MEM_ADDRESS_WIDTH-1:0] memAddress,
    output logic [3:0]                   memByteSelect,
    output logic                         memEnable,
    output logic                         memWriteEnable,
    output logic [MEM_DATA_WIDTH-1:0]    memDataWrite,
    input  logic [MEM_DATA_WIDTH-1:0]    memDataRead,
    input  logic                         memBusy
);

    arbState_t state;
    logic      grantCore;
    logic      grantWb;
    logic      wbForced;
    logic      starveAtLimit;

    // Grant is decided in the same cycle as the request; an owner keeps the
    // port only while it holds its enable.
    always_comb begin
        grantCore = 1'b0;
        grantWb   = 1'b0;
        wbForced  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    wbForced  = wbEnable && starveAtLimit;
                    grantWb   = wbForced || (wbEnable && !coreEnable);
                    grantCore = coreEnable && !wbForced;
                end
                OWN_CORE: grantCore = coreEnable;
                OWN_WB:   grantWb   = wbEnable;
                default: ;
            endcase
        end
    end

    always_comb begin
        memAddress     = '0;
        memByteSelect  = '0;
        memEnable      = 1'b0;
        memWriteEnable = 1'b0;
        memDataWrite   = '0;
        if (grantCore) begin
            memAddress     = coreAddress;
            memByteSelect  = coreByteSelect;
            memEnable      = 1'b1;
            memWriteEnable = coreWriteEnable;
            memDataWrite   = coreDataWrite;
        end else if (grantWb) begin
            memAddress     = wbAddress;
            memByteSelect  = wbByteSelect;
            memEnable      = 1'b1;
            memWriteEnable = wbWriteEnable;
            memDataWrite   = wbDataWrite;
        end
        coreBusy     = grantCore ? memBusy : coreEnable;
        wbBusy       = grantWb   ? memBusy : wbEnable;
        coreDataRead = grantCore ? memDataRead : MEM_IDLE_READ;
        wbDataRead   = grantWb   ? memDataRead : MEM_IDLE_READ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (grantCore && memBusy) begin
                        state <= OWN_CORE;
                    end else if (grantWb && memBusy) begin
                        state <= OWN_WB;
                    end
                end
                OWN_CORE: if (!coreEnable || !memBusy) state <= IDLE;
                OWN_WB:   if (!wbEnable || !memBusy) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    arbiter_starvation_counter #(
        .LIMIT (STARVATION_LIMIT),
        .WIDTH (STARVE_COUNT_WIDTH)
    ) starveCounter (
        .clk     (clk),
        .rst     (rst),
        .inc     (wbEnable && !grantWb),
        .clear   (!wbEnable || grantWb),
        .atLimit (starveAtLimit)
    );

`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
    // A transaction starts only when a grant is issued from IDLE.
    logic startCore;
    logic startWb;
    logic startForced;

    assign startCore   = (state == IDLE) && grantCore;
    assign startWb     = (state == IDLE) && grantWb;
    assign startForced = (state == IDLE) && wbForced;

    always_ff @(posedge clk) begin
        if (rst || statsClear) begin
            coreGrantCount     <= '0;
            wbGrantCount       <= '0;
            wbForcedGrantCount <= '0;
        end else begin
            coreGrantCount     <= satInc16(coreGrantCount, startCore);
            wbGrantCount       <= satInc16(wbGrantCount, startWb);
            wbForcedGrantCount <= satInc16(wbForcedGrantCount, startForced);
        end
    end
`endif

endmodule

// File: tb/tb_local_memory_arbiter.sv
// Directed bench for local_memory_arbiter: the stimulus pushes the expected
// per-cycle bus picture into a queue, a negedge monitor pops and compares.
module tb_local_memory_arbiter;

    localparam logic [23:0] CORE_ADDR  = 24'h000100;
    localparam logic [23:0] WB_ADDR    = 24'h000200;
    localparam logic [3:0]  CORE_BS    = 4'hF;
    localparam logic [3:0]  WB_BS      = 4'h3;
    localparam logic [31:0] CORE_WDATA = 32'hC0C0_0001;
    localparam logic [31:0] WB_WDATA   = 32'hB0B0_0002;
    localparam logic [31:0] IDLE_READ  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] coreAddress;
    logic [3:0]  coreByteSelect;
    logic        coreEnable;
    logic        coreWriteEnable;
    logic [31:0] coreDataWrite;
    logic [31:0] coreDataRead;
    logic        coreBusy;
    logic [23:0] wbAddress;
    logic [3:0]  wbByteSelect;
    logic        wbEnable;
    logic        wbWriteEnable;
    logic [31:0] wbDataWrite;
    logic [31:0] wbDataRead;
    logic        wbBusy;
    logic [23:0] memAddress;
    logic [3:0]  memByteSelect;
    logic        memEnable;
    logic        memWriteEnable;
    logic [31:0] memDataWrite;
    logic [31:0] memDataRead;
    logic        memBusy;
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
    logic        statsClear;
    logic [15:0] coreGrantCount;
    logic [15:0] wbGrantCount;
    logic [15:0] wbForcedGrantCount;
`endif

    always #5 clk = ~clk;

    local_memory_arbiter #(
        .STARVATION_LIMIT   (8),
        .STARVE_COUNT_WIDTH (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .coreAddress        (coreAddress),
        .coreByteSelect     (coreByteSelect),
        .coreEnable         (coreEnable),
        .coreWriteEnable    (coreWriteEnable),
        .coreDataWrite      (coreDataWrite),
        .coreDataRead       (coreDataRead),
        .coreBusy           (coreBusy),
        .wbAddress          (wbAddress),
        .wbByteSelect       (wbByteSelect),
        .wbEnable           (wbEnable),
        .wbWriteEnable      (wbWriteEnable),
        .wbDataWrite        (wbDataWrite),
        .wbDataRead         (wbDataRead),
        .wbBusy             (wbBusy),
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
        .statsClear         (statsClear),
        .coreGrantCount     (coreGrantCount),
        .wbGrantCount       (wbGrantCount),
        .wbForcedGrantCount (wbForcedGrantCount),
`endif
        .memAddress         (memAddress),
        .memByteSelect      (memByteSelect),
        .memEnable          (memEnable),
        .memWriteEnable     (memWriteEnable),
        .memDataWrite       (memDataWrite),
        .memDataRead        (memDataRead),
        .memBusy            (memBusy)
    );

    // owner: 0 = nobody on the memory port, 1 = core, 2 = wishbone
    typedef struct {
        int          id;
        int          owner;
        logic        coreBusyExp;
        logic        wbBusyExp;
        logic [31:0] memData;
    } expect_t;

    expect_t expQ[$];
    int      nCompared = 0;
    int      nMismatched = 0;
    int      stepNo = 0;
    bit      stimDone = 1'b0;

    function automatic void check(input int id, input string name,
                                  input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("FAIL step%0d %s actual=%h expected=%h", id, name, actual, expected);
        end
    endfunction

    task automatic step(input bit r, input bit ce, input bit we, input bit mb,
                        input int owner, input bit cb, input bit wbb);
        expect_t e;
        rst         = r;
        coreEnable  = ce;
        wbEnable    = we;
        memBusy     = mb;
        memDataRead = 32'hD000_0000 + 32'(stepNo);
        e.id          = stepNo;
        e.owner       = owner;
        e.coreBusyExp = cb;
        e.wbBusyExp   = wbb;
        e.memData     = memDataRead;
        expQ.push_back(e);
        stepNo++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents a full bus picture every cycle.
    initial begin
        expect_t e;
        logic [23:0] eAddr;
        logic [3:0]  eBs;
        logic        eEn;
        logic        eWe;
        logic [31:0] eDw;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                eEn   = (e.owner != 0);
                eAddr = (e.owner == 1) ? CORE_ADDR  : (e.owner == 2) ? WB_ADDR  : 24'h0;
                eBs   = (e.owner == 1) ? CORE_BS    : (e.owner == 2) ? WB_BS    : 4'h0;
                eWe   = (e.owner == 2);
                eDw   = (e.owner == 1) ? CORE_WDATA : (e.owner == 2) ? WB_WDATA : 32'h0;
                check(e.id, "memEnable",      32'(memEnable),      32'(eEn));
                check(e.id, "memAddress",     32'(memAddress),     32'(eAddr));
                check(e.id, "memByteSelect",  32'(memByteSelect),  32'(eBs));
                check(e.id, "memWriteEnable", 32'(memWriteEnable), 32'(eWe));
                check(e.id, "memDataWrite",   memDataWrite,        eDw);
                check(e.id, "coreBusy",       32'(coreBusy),       32'(e.coreBusyExp));
                check(e.id, "wbBusy",         32'(wbBusy),         32'(e.wbBusyExp));
                check(e.id, "coreDataRead",   coreDataRead, (e.owner == 1) ? e.memData : IDLE_READ);
                check(e.id, "wbDataRead",     wbDataRead,   (e.owner == 2) ? e.memData : IDLE_READ);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst             = 1'b1;
        coreAddress     = CORE_ADDR;
        coreByteSelect  = CORE_BS;
        coreEnable      = 1'b0;
        coreWriteEnable = 1'b0;
        coreDataWrite   = CORE_WDATA;
        wbAddress       = WB_ADDR;
        wbByteSelect    = WB_BS;
        wbEnable        = 1'b0;
        wbWriteEnable   = 1'b1;
        wbDataWrite     = WB_WDATA;
        memDataRead     = 32'h0;
        memBusy         = 1'b0;
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
        statsClear      = 1'b0;
`endif
        @(posedge clk);
        #1;

        // reset: port idle, busy mirrors enable      r  ce we mb own cb wb
        step(1, 1, 1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // core read alone, memory busy for one cycle
        step(0, 1, 0, 1, 1, 1, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // simultaneous request: core first, wishbone the next cycle
        step(0, 1, 1, 0, 1, 0, 1);
        step(0, 0, 1, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // core streaming: wishbone forced in on its 9th waiting cycle
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 1, 0, 1);
        step(0, 1, 1, 0, 2, 1, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // wishbone owns for 4 busy cycles, core waits then gets the port
        step(0, 0, 1, 1, 2, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 2, 1, 1);
        step(0, 1, 1, 0, 2, 1, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // core aborts mid-transaction, wishbone granted after
        step(0, 1, 1, 1, 1, 1, 1);
        step(0, 0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // reset while wishbone owns: grant dropped, arbiter back in IDLE
        step(0, 0, 1, 1, 2, 0, 1);
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
        check(stepNo, "coreGrantCount",     32'(coreGrantCount),     32'd13);
        check(stepNo, "wbGrantCount",       32'(wbGrantCount),       32'd5);
        check(stepNo, "wbForcedGrantCount", 32'(wbForcedGrantCount), 32'd1);
`endif
        step(1, 0, 1, 1, 0, 0, 1);
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
        check(stepNo, "coreGrantCount",     32'(coreGrantCount),     32'd0);
        check(stepNo, "wbGrantCount",       32'(wbGrantCount),       32'd0);
        check(stepNo, "wbForcedGrantCount", 32'(wbForcedGrantCount), 32'd0);
`endif
        step(0, 1, 1, 0, 1, 0, 1);
        step(0, 0, 1, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        stimDone = 1'b1;
        @(negedge clk);
        check(stepNo, "queueDrained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
